// File: rtl/data_bus_pkg.sv
// Shared definitions for the data-memory bus masters.
// Provides the master FSM state type, default bus widths, and the
// round-robin pointer advance used by the arbiter and the master.
package data_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Advance a round-robin index by one, wrapping at n.
    function automatic int next_rr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req     - request vector, one bit per core
//   rr_ptr  - index that has highest priority this round
//   winner  - first requesting index at or after rr_ptr (modulo NUM_CORES)
//   any_req - at least one request bit is set
module rr_pick
    import data_bus_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [IDX_W-1:0]     winner,
    output logic                 any_req
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the ring starting at rr_ptr; the first set bit wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = rr_ptr;
        for (int off = 0; off < NUM_CORES; off++) begin
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = IDX_W'(next_rr(int'(cand), NUM_CORES));
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/data_bus_master.sv
// Read-side initiator for the shared data memory.
// Arbitrates per-core read requests round-robin, drives a registered
// address to the memory, captures the memory's combinational data one
// cycle later and returns it to the winning core with a one-cycle ack.
// Ports:
//   clk, reset (async, active-low)
//   req[NUM_CORES], req_addr[NUM_CORES*ADDR_W]  - per-core requests
//   ack[NUM_CORES], rd_data[NUM_CORES*DATA_W]   - per-core results
//   mem_addr[ADDR_W] (out), mem_data[DATA_W] (in) - memory read port
//   busy - high while a read is outstanding (state READ)
module data_bus_master
    import data_bus_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    output logic [NUM_CORES-1:0]        ack,
    output logic [NUM_CORES*DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_data,
    output logic                        busy
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                    win_idx_q, win_idx_d;
    logic [ADDR_W-1:0]                   mem_addr_q, mem_addr_d;
    logic [NUM_CORES-1:0]                ack_q, ack_d;
    logic [NUM_CORES-1:0][DATA_W-1:0]    rd_data_q, rd_data_d;

    logic [NUM_CORES-1:0][ADDR_W-1:0]    addr_v;
    logic [IDX_W-1:0]                    winner;
    logic                                any_req;

    assign addr_v = req_addr;

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_idx_d  = win_idx_q;
        mem_addr_d = mem_addr_q;
        rd_data_d  = rd_data_q;
        ack_d      = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    win_idx_d  = winner;
                    mem_addr_d = addr_v[winner];
                    state_d    = READ;
                end
            end
            READ: begin
                // mem_data reflects mem_addr_q, latched on entry to READ,
                // so later req_addr changes cannot disturb this read.
                rd_data_d[win_idx_q] = mem_data;
                ack_d[win_idx_q]     = 1'b1;
                rr_ptr_d             = IDX_W'(next_rr(int'(win_idx_q), NUM_CORES));
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            win_idx_q  <= '0;
            mem_addr_q <= '0;
            ack_q      <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_idx_q  <= win_idx_d;
            mem_addr_q <= mem_addr_d;
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign ack      = ack_q;
    assign rd_data  = rd_data_q;
    assign mem_addr = mem_addr_q;
    assign busy     = (state_q == READ);

endmodule

// File: tb/tb_data_bus_master.sv
// Directed bench for data_bus_master with a small behavioural model of the
// data memory's power-up contents.
module tb_data_bus_master;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [3:0]  ack;
    logic [31:0] rd_data;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    data_bus_master #(
        .NUM_CORES (4),
        .ADDR_W    (8),
        .DATA_W    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .ack      (ack),
        .rd_data  (rd_data),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy)
    );

    // Memory power-up contents at the addresses used below; other
    // addresses hold addr ^ 8'hA5.
    function automatic logic [7:0] mem_val(input logic [7:0] a);
        case (a)
            8'd0:   return 8'd74;
            8'd1:   return 8'd107;
            8'd3:   return 8'd254;
            8'd4:   return 8'd37;
            8'd5:   return 8'd97;
            8'd8:   return 8'd93;
            8'd9:   return 8'd53;
            8'd12:  return 8'd169;
            8'd16:  return 8'd73;
            8'd255: return 8'd225;
            default: return a ^ 8'hA5;
        endcase
    endfunction

    assign mem_data = mem_val(mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int core, input logic [7:0] a);
        req_addr[core*8 +: 8] = a;
    endtask

    function automatic logic [7:0] rd(input int core);
        return rd_data[core*8 +: 8];
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    logic [7:0] exp_d [4];
    logic [7:0] addr4 [4];

    initial begin
        reset    = 1'b0;
        req      = '0;
        req_addr = '0;
        tick();
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b1;
        tick();

        // Single read from core 0, address 3
        set_addr(0, 8'd3);
        req = 4'b0001;
        tick();
        check("single_busy", 32'(busy), 1);
        check("single_ack_early", 32'(ack), 0);
        check("single_mem_addr", 32'(mem_addr), 3);
        tick();
        check("single_ack", 32'(ack), 32'b0001);
        check("single_data", 32'(rd(0)), 254);
        check("single_busy_done", 32'(busy), 0);
        req = '0;
        tick();
        check("single_ack_clear", 32'(ack), 0);

        // Simultaneous requests: served 0,1,2,3 after a fresh reset
        do_reset();
        check("rst2_rd_data", rd_data, 0);
        addr4[0] = 8'd0;  addr4[1] = 8'd5;  addr4[2] = 8'd12; addr4[3] = 8'd255;
        exp_d[0] = 8'd74; exp_d[1] = 8'd97; exp_d[2] = 8'd169; exp_d[3] = 8'd225;
        for (int k = 0; k < 4; k++) set_addr(k, addr4[k]);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("sim_addr%0d", k), 32'(mem_addr), 32'(addr4[k]));
            tick();
            check($sformatf("sim_ack%0d", k), 32'(ack), 32'(1 << k));
            check($sformatf("sim_data%0d", k), 32'(rd(k)), 32'(exp_d[k]));
            req[k] = 1'b0;
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("sim_hold%0d", k), 32'(rd(k)), 32'(exp_d[k]));
        tick();

        // Fairness: cores 0 and 2 request continuously
        do_reset();
        set_addr(0, 8'd1);
        set_addr(2, 8'd4);
        req = 4'b0101;
        for (int t = 0; t < 8; t++) begin
            tick();
            check($sformatf("fair_addr%0d", t), 32'(mem_addr), (t % 2 == 0) ? 1 : 4);
            tick();
            check($sformatf("fair_ack%0d", t), 32'(ack), (t % 2 == 0) ? 32'b0001 : 32'b0100);
            if (t % 2 == 0) check($sformatf("fair_data%0d", t), 32'(rd(0)), 107);
            else            check($sformatf("fair_data%0d", t), 32'(rd(2)), 37);
        end
        check("fair_core1", 32'(rd(1)), 0);
        check("fair_core3", 32'(rd(3)), 0);
        req = '0;
        tick();

        // Address change while READ: latched address completes
        set_addr(1, 8'd8);
        req = 4'b0010;
        tick();
        check("achg_busy", 32'(busy), 1);
        set_addr(1, 8'd9);
        #1;
        check("achg_mem_addr", 32'(mem_addr), 8);
        tick();
        check("achg_ack", 32'(ack), 32'b0010);
        check("achg_data", 32'(rd(1)), 93);
        req = '0;
        tick();

        // Reset asserted mid-READ
        set_addr(3, 8'd16);
        req = 4'b1000;
        tick();
        check("rmid_busy", 32'(busy), 1);
        check("rmid_mem_addr", 32'(mem_addr), 16);
        reset = 1'b0;
        #1;
        check("rmid_busy_clr", 32'(busy), 0);
        check("rmid_addr_clr", 32'(mem_addr), 0);
        check("rmid_ack_clr", 32'(ack), 0);
        check("rmid_data_clr", rd_data, 0);
        tick();
        check("rmid_no_ack", 32'(ack), 0);
        reset = 1'b1;
        tick();
        check("rmid_regrant", 32'(mem_addr), 16);
        tick();
        check("rmid_ack3", 32'(ack), 32'b1000);
        check("rmid_data3", 32'(rd(3)), 73);
        req = '0;
        tick();

        // Pointer wrap: core 3 just served, so core 0 wins next
        set_addr(0, 8'd2);
        set_addr(3, 8'd7);
        req = 4'b1001;
        tick();
        check("wrap_addr0", 32'(mem_addr), 2);
        tick();
        check("wrap_ack0", 32'(ack), 32'b0001);
        check("wrap_data0", 32'(rd(0)), 32'(8'd2 ^ 8'hA5));
        req[0] = 1'b0;
        tick();
        check("wrap_addr3", 32'(mem_addr), 7);
        tick();
        check("wrap_ack3", 32'(ack), 32'b1000);
        check("wrap_data3", 32'(rd(3)), 32'(8'd7 ^ 8'hA5));
        req = '0;
        tick();
        check("wrap_idle_ack", 32'(ack), 0);

        // Request dropped during READ still completes
        set_addr(2, 8'd12);
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        check("drop_ack", 32'(ack), 32'b0100);
        check("drop_data", 32'(rd(2)), 169);
        check("drop_core0_hold", 32'(rd(0)), 32'(8'd2 ^ 8'hA5));
        tick();
        check("drop_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_master.md
Name: data_bus_master

Overview:
- Read-side initiator for the single-bus data memory in the multicore build.
- Arbitrates read requests from NUM_CORES cores using round-robin.
- Drives the memory's 8-bit address bus, samples the memory's combinational data bus, and returns each read word to the requesting core with a one-cycle ack pulse.
- Lets several cores share the one memory read port without conflicts.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset==0 clears all state immediately.
- req  input  NUM_CORES  per-core read request, level.
- req_addr  input  NUM_CORES*ADDR_W  per-core read address, flattened; core i uses bits [i*ADDR_W +: ADDR_W].
- ack  output  NUM_CORES  per-core one-cycle completion pulse.
- rd_data  output  NUM_CORES*DATA_W  per-core read result, flattened the same way as req_addr; holds its value until the next ack to that core.
- mem_addr  output  ADDR_W  registered address; connects to the memory's addr_bus_0 and is driven continuously (no tri-state).
- mem_data  input  DATA_W  connects to the memory's data_bus_0; combinational data for mem_addr.
- busy  output  1  high while in state READ.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, rr_ptr=0, win_idx=0.
  - mem_addr=0, ack=0, all rd_data=0, busy=0.
- FSM states: IDLE, READ.
- IDLE, on a clock edge:
  - If no req bit is set: stay IDLE. ack=0, mem_addr holds its value.
  - If any req bit is set: select a winner by searching rr_ptr, rr_ptr+1, ... modulo NUM_CORES; the first set bit wins.
  - Latch win_idx=winner and mem_addr=req_addr[winner]; go to READ.
- READ, on the next clock edge:
  - rd_data[win_idx] <= mem_data; ack[win_idx] <= 1.
  - rr_ptr <= (win_idx+1) mod NUM_CORES; go to IDLE.
- ack is registered and is high for exactly the one cycle after leaving READ; at most one ack bit is ever set.
- Latency and throughput:
  - A req first sampled in IDLE sees ack 2 edges later.
  - Peak throughput is one read per 2 cycles.
- Handshake rules:
  - A core holds req and req_addr stable until it sees ack.
  - req still high during the ack cycle counts as a new request and is eligible at that same IDLE edge.
- Boundary conditions:
  - req_addr is sampled only in IDLE. Changes during READ are ignored; the latched address completes.
  - If req drops during READ, the transaction still completes and ack still pulses; the core ignores it.
  - Simultaneous requests are served strictly round-robin. Any continuously requesting core is served within NUM_CORES grants (no starvation).
  - rr_ptr wrap: win_idx=NUM_CORES-1 sets rr_ptr=0.
  - Address wrap needs no special handling: address 255 is a normal address.
  - Reset asserted mid-READ: the transaction is aborted, no ack is issued, and outputs clear in the same cycle without waiting for an edge.
  - After reset deasserts, arbitration restarts at core 0.
  - rd_data of non-winning cores never changes.

Decomposition:
- Package data_bus_pkg:
  - state_t enum {IDLE, READ}.
  - ADDR_W/DATA_W defaults.
  - Function next_rr(idx, n) computing the pointer wrap.
- One sub-module, rr_pick (combinational):
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any_req.
  - Reused by the planned write-port master.

Test Plan (memory instantiated with its power-up contents, reset held low ≥2 cycles first):
- Single read: req[0]=1, addr 3 -> ack[0] pulses 2 edges later; rd_data core0=254; busy high one cycle.
- Simultaneous: all 4 cores request with addrs 0, 5, 12, 255 -> acks in order core0, 1, 2, 3, spaced 2 cycles; data 74, 97, 169, 225.
- Fairness: core0 and core2 hold req continuously (addrs 1, 4) -> grants alternate 0, 2, 0, 2 for 8 transactions; data 107, 37 alternating; core1/core3 rd_data stay 0.
- Address change mid-READ: core1 addr 8 changed to 9 in the READ cycle -> rd_data core1=93 (mem[8]), not 53.
- Reset mid-READ: core3 addr 16, reset pulled low in the READ cycle -> all outputs 0 immediately, no ack. After release, a new core3 request returns 73.
- Pointer wrap: core3 is served, then core0 and core3 request together -> core0 wins first.
